// File: rtl/alu_rr_sched_if.sv
// rtl/alu_rr_sched_if.sv - two-requester operation bundle plus registered response for alu_rr_sched
interface alu_rr_sched_if #(
  parameter int WIDTH = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_in1;
  logic [WIDTH-1:0] req0_in2;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_in1;
  logic [WIDTH-1:0] req1_in2;
  logic [1:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [3:0]       rsp_dec;
  logic [3:0]       rsp_unis;
  logic             rsp_zero;
  logic             rsp_error;

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_op,
    input  req0_ready,
    output req1_valid, req1_in1, req1_in2, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_op,
    output req0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin two-requester ALU with decimal-split registered response
module alu_rr_sched #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  alu_rr_sched_if.slave bus,
  output logic [7:0]    op_count,
  output logic [7:0]    err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic             grant_valid;
  logic             grant_id;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [3:0]       rsp_dec_q;
  logic [3:0]       rsp_unis_q;
  logic             rsp_zero_q;
  logic             rsp_error_q;

  logic [5:0]       a6;
  logic [5:0]       b6;
  logic [5:0]       alu_r;
  logic             alu_err;
  logic             alu_div0;
  logic [3:0]       alu_dec;
  logic [3:0]       alu_unis;

  // A tie goes to whoever was not served last; last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset && ena && state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_valid && !grant_id;
  assign bus.req1_ready = grant_valid &&  grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results live in 6 bits; products and sums wrap modulo 64.
  always_comb begin
    a6       = 6'(a_q);
    b6       = 6'(b_q);
    alu_r    = 6'd0;
    alu_err  = 1'b0;
    alu_div0 = 1'b0;
    case (op_q)
      2'd0: alu_r = a6 + b6;
      2'd1: begin
        if (a_q >= b_q) alu_r = a6 - b6;
        else            alu_err = 1'b1;
      end
      2'd2: alu_r = a6 * b6;
      default: begin
        if (b_q == '0) begin
          alu_err  = 1'b1;
          alu_div0 = 1'b1;
          alu_r    = 6'd63;
        end else begin
          alu_r = 6'(a_q / b_q);
        end
      end
    endcase
    alu_dec  = alu_div0 ? 4'd15 : 4'(alu_r / 6'd10);
    alu_unis = alu_div0 ? 4'd15 : 4'(alu_r % 6'd10);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 2'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_dec_q    <= 4'd0;
      rsp_unis_q   <= 4'd0;
      rsp_zero_q   <= 1'b0;
      rsp_error_q  <= 1'b0;
      op_count     <= 8'd0;
      err_count    <= 8'd0;
    end else if (ena) begin
      state_q <= state_d;
      if (grant_valid) begin
        id_q <= grant_id;
        a_q  <= grant_id ? bus.req1_in1 : bus.req0_in1;
        b_q  <= grant_id ? bus.req1_in2 : bus.req0_in2;
        op_q <= grant_id ? bus.req1_op  : bus.req0_op;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_dec_q   <= alu_dec;
        rsp_unis_q  <= alu_unis;
        rsp_zero_q  <= (alu_r == 6'd0);
        rsp_error_q <= alu_err;
        if (op_count != 8'hFF) op_count <= op_count + 8'd1;
        if (alu_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q  <= 1'b0;
        last_grant_q <= rsp_id_q;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_dec   = rsp_dec_q;
  assign bus.rsp_unis  = rsp_unis_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
